counter_datapath_unit: RTL

- Downstream of the counter controller unit. Consumes its level outputs `enable`, `clear` and `mode`, and produces the 0..COUNT_MAX count value that drives the FND display stage.
- Contains a tick prescaler and a two-state run/stop FSM.
- Advances an up/down wrap-around counter once per tick while running.

---
 rtl/counter_pkg.sv | 69 ++++++
 rtl/tick_gen.sv | 55 +++++
 rtl/counter_datapath_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Purpose  : Shared types and helpers for the counter datapath unit: default
//            count width, count-direction encodings, run/stop state type and
//            BCD digit helpers used when COUNTER_BCD_OUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

  localparam int unsigned COUNT_W = 14;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  typedef enum logic [0:0] {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  // Four-digit packed BCD of a binary value (ones digit in [3:0]).
  function automatic logic [15:0] to_bcd(input int unsigned v);
    int unsigned t;
    logic [15:0] r;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // One step of a cascaded BCD counter; each digit carries on 9->0 (up)
  // or borrows on 0->9 (down) into the next digit.
  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic down);
    logic [15:0] r;
    logic        carry;
    bcd_digit_t  d;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = v[i*4 +: 4];
      if (carry) begin
        if (down) begin
          if (d == 4'd0) begin
            d = 4'd9;
          end else begin
            d     = d - 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == 4'd9) begin
            d = 4'd0;
          end else begin
            d     = d + 4'd1;
            carry = 1'b0;
          end
        end
      end
      r[i*4 +: 4] = d;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Purpose  : Run-gated prescaler counting 0..DIV-1. Advances only while
//            i_run is high and holds its phase otherwise.
// Ports    : clk      - clock
//            rst      - asynchronous active-low reset
//            i_run    - advance enable (registered RUN state)
//            i_clear  - synchronous clear of prescaler and tick
//            o_strobe - terminal-cycle strobe (combinational from registers),
//                       high during the cycle whose closing edge emits a tick
//            o_tick   - registered one-cycle tick pulse
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_clear,
  output logic o_strobe,
  output logic o_tick
);

  localparam int unsigned C_PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [C_PW-1:0] c_last = C_PW'(DIV - 1);
  localparam logic [C_PW-1:0] c_one  = C_PW'(1);

  logic [C_PW-1:0] r_presc;
  logic            r_tick;

  // Clear suppresses the strobe so a coincident clear never counts.
  assign o_strobe = i_run & ~i_clear & (r_presc == c_last);
  assign o_tick   = r_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (i_clear) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= o_strobe;
      if (o_strobe) begin
        r_presc <= '0;
      end else if (i_run) begin
        r_presc <= r_presc + c_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/counter_datapath_unit.sv
`default_nettype none
// ============================================================================
// Module   : counter_datapath_unit
// Purpose  : Run/stop FSM, tick prescaler and up/down wrap-around counter
//            (0..COUNT_MAX) feeding the FND display stage.
// Ports    : clk    - clock
//            rst    - asynchronous active-low reset
//            enable - 1 = run, 0 = pause (prescaler phase is kept)
//            clear  - synchronous clear of count, prescaler, tick, wrap
//            mode   - direction, MODE_UP / MODE_DOWN, sampled at tick edges
//            count  - registered count value
//            tick   - one-cycle pulse per prescaler terminal cycle in RUN
//            wrap   - one-cycle pulse coincident with a wrapping update
//            bcd    - (COUNTER_BCD_OUT_EN only) 4-digit BCD of count
// Option   : COUNTER_BCD_OUT_EN adds the bcd port and cascaded BCD counter.
// Revision : 1.0 - initial release
// ============================================================================
module counter_datapath_unit
  import counter_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned TICK_HZ     = 10,
  parameter int unsigned COUNT_MAX   = 9999,
  parameter int unsigned COUNT_W     = counter_pkg::COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               clear,
  input  logic               mode,
  output logic [COUNT_W-1:0] count,
  output logic               tick,
  output logic               wrap
`ifdef COUNTER_BCD_OUT_EN
  ,
  output logic [15:0]        bcd
`endif
);

  localparam int unsigned C_DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam logic [COUNT_W-1:0] c_max = COUNT_W'(COUNT_MAX);
  localparam logic [COUNT_W-1:0] c_one = COUNT_W'(1);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_run;
  logic               w_strobe;
  logic               w_at_max;
  logic               w_at_zero;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] w_count_next;
  logic               r_wrap;
  logic               w_wrap_next;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= STOP;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_run        = 1'b0;
    case (r_state)
      STOP: begin
        if (enable) w_state_next = RUN;
      end
      RUN: begin
        w_run = 1'b1;
        if (!enable) w_state_next = STOP;
      end
      default: w_state_next = STOP;
    endcase
  end

  // ---------------------------------------------------------- prescaler
  // Run decision uses the registered state, so an enable drop on the
  // terminal edge still lets that update through.
  tick_gen #(
    .DIV (C_DIV)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .i_run    (w_run),
    .i_clear  (clear),
    .o_strobe (w_strobe),
    .o_tick   (tick)
  );

  // ------------------------------------------------------------ counter
  assign w_at_max  = (r_count == c_max);
  assign w_at_zero = (r_count == '0);

  always_comb begin
    w_count_next = r_count;
    w_wrap_next  = 1'b0;
    if (w_strobe) begin
      if (mode == MODE_UP) begin
        if (w_at_max) begin
          w_count_next = '0;
          w_wrap_next  = 1'b1;
        end else begin
          w_count_next = r_count + c_one;
        end
      end else begin
        if (w_at_zero) begin
          w_count_next = c_max;
          w_wrap_next  = 1'b1;
        end else begin
          w_count_next = r_count - c_one;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_wrap  <= w_wrap_next;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;

`ifdef COUNTER_BCD_OUT_EN
  // ---------------------------------------------------- BCD shadow count
  // Tracks count digit-by-digit so no binary-to-BCD divider is needed.
  localparam logic [15:0] c_bcd_max = to_bcd(COUNT_MAX);

  logic [15:0] r_bcd;
  logic [15:0] w_bcd_next;

  always_comb begin
    w_bcd_next = r_bcd;
    if (w_strobe) begin
      if (mode == MODE_UP) begin
        w_bcd_next = w_at_max ? 16'h0000 : bcd_step(r_bcd, 1'b0);
      end else begin
        w_bcd_next = w_at_zero ? c_bcd_max : bcd_step(r_bcd, 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcd <= '0;
    end else if (clear) begin
      r_bcd <= '0;
    end else begin
      r_bcd <= w_bcd_next;
    end
  end

  assign bcd = r_bcd;
`endif

endmodule
`default_nettype wire
